// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory read-response path.
//   - mem_sel encodings produced by the address decoder
//   - load funct3 codes
//   - read FSM state type
//   - f3_legal(): true for the five supported load types
package mem_pkg;

   localparam logic [1:0] SEL_SRAM = 2'b00;
   localparam logic [1:0] SEL_UART = 2'b01;
   localparam logic [1:0] SEL_I2C  = 2'b10;
   localparam logic [1:0] SEL_NONE = 2'b11;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_e;

   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational load alignment and sign/zero extension.
//   word     in  32  raw device word
//   addr_lo  in  2   byte offset within the word
//   funct3   in  3   load type
//   data     out 32  selected field, sign- or zero-extended (0 for illegal funct3)
//   misalign out 1   LW not word aligned, or LH/LHU not half aligned
// Kept separate so the store path can reuse the same lane selection.
module load_extend
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] data,
   output logic        misalign
);

   logic [31:0] shifted;
   logic [7:0]  byte_f;
   logic [15:0] half_f;

   always_comb begin
      shifted  = word >> {addr_lo, 3'b000};
      byte_f   = shifted[7:0];
      half_f   = addr_lo[1] ? word[31:16] : word[15:0];
      data     = 32'h0;
      misalign = 1'b0;
      case (funct3)
         F3_LB:  data = {{24{byte_f[7]}}, byte_f};
         F3_LBU: data = {24'h0, byte_f};
         F3_LH: begin
            data     = {{16{half_f[15]}}, half_f};
            misalign = addr_lo[0];
         end
         F3_LHU: begin
            data     = {16'h0, half_f};
            misalign = addr_lo[0];
         end
         F3_LW: begin
            data     = word;
            misalign = (addr_lo != 2'b00);
         end
         default: data = 32'h0;
      endcase
   end

endmodule

// File: rtl/mem_read_resp.sv
// mem_read_resp: single-outstanding load engine behind the address decoder.
// Accepts one load in IDLE, strobes the selected device for one cycle,
// collects the word, aligns/extends it and returns it with a one-cycle
// rsp_valid pulse. Illegal requests skip the device and respond with rsp_err.
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             load handshake (ready only in IDLE)
//   req_mem_sel/req_addr/req_funct3 request fields
//   rd_addr                         latched request address
//   sram/uart/i2c_rd_en             one-cycle read strobes
//   sram_rdata, uart_/i2c_rdata     device read data, uart_/i2c_rvalid qualifiers
//   rsp_valid/rsp_data/rsp_err      response
// Optional build macro MEM_RSP_TIMEOUT_EN: UART/I2C waits give up after
// TIMEOUT_CYCLES WAIT cycles and respond with rsp_err.
module mem_read_resp
   import mem_pkg::*;
#(
   parameter int SRAM_LAT       = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_mem_sel,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_funct3,
   output logic [31:0] rd_addr,
   output logic        sram_rd_en,
   output logic        uart_rd_en,
   output logic        i2c_rd_en,
   input  logic [31:0] sram_rdata,
   input  logic [31:0] uart_rdata,
   input  logic        uart_rvalid,
   input  logic [31:0] i2c_rdata,
   input  logic        i2c_rvalid,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_err
);

   // One down-counter serves both the SRAM latency and the UART/I2C timeout.
   localparam int MAXV = (SRAM_LAT > TIMEOUT_CYCLES) ? SRAM_LAT : TIMEOUT_CYCLES;
   localparam int CW   = (MAXV < 2) ? 1 : $clog2(MAXV + 1);

   state_e      state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  f3_q, f3_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        sram_rd_en_q, sram_rd_en_d;
   logic        uart_rd_en_q, uart_rd_en_d;
   logic        i2c_rd_en_q, i2c_rd_en_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_data_q, rsp_data_d;

   logic [31:0] dev_word, ext_data;
   logic [1:0]  ext_addr;
   logic [2:0]  ext_f3;
   logic        ext_misalign, dev_rvalid;

   // In IDLE the extender checks the incoming request; afterwards it
   // formats the captured word using the latched fields.
   assign ext_addr = (state_q == ST_IDLE) ? req_addr[1:0] : addr_q[1:0];
   assign ext_f3   = (state_q == ST_IDLE) ? req_funct3    : f3_q;

   always_comb begin
      dev_word   = sram_rdata;
      dev_rvalid = 1'b0;
      case (sel_q)
         SEL_UART: begin dev_word = uart_rdata; dev_rvalid = uart_rvalid; end
         SEL_I2C:  begin dev_word = i2c_rdata;  dev_rvalid = i2c_rvalid;  end
         default:  begin dev_word = sram_rdata; dev_rvalid = 1'b0;        end
      endcase
   end

   load_extend u_ext (
      .word    (dev_word),
      .addr_lo (ext_addr),
      .funct3  (ext_f3),
      .data    (ext_data),
      .misalign(ext_misalign)
   );

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      addr_d       = addr_q;
      f3_d         = f3_q;
      cnt_d        = cnt_q;
      sram_rd_en_d = 1'b0;
      uart_rd_en_d = 1'b0;
      i2c_rd_en_d  = 1'b0;
      rsp_valid_d  = 1'b0;
      rsp_err_d    = rsp_err_q;
      rsp_data_d   = rsp_data_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               sel_d  = req_mem_sel;
               addr_d = req_addr;
               f3_d   = req_funct3;
               if (req_mem_sel == SEL_NONE || ext_misalign || !f3_legal(req_funct3)) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = 32'h0;
               end else begin
                  state_d      = ST_ISSUE;
                  sram_rd_en_d = (req_mem_sel == SEL_SRAM);
                  uart_rd_en_d = (req_mem_sel == SEL_UART);
                  i2c_rd_en_d  = (req_mem_sel == SEL_I2C);
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            cnt_d   = (sel_q == SEL_SRAM) ? CW'(SRAM_LAT - 1) : CW'(TIMEOUT_CYCLES - 1);
            // A peripheral may answer in the strobe cycle itself.
            if (dev_rvalid) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_data_d  = ext_data;
            end
         end
         ST_WAIT: begin
            if (sel_q == SEL_SRAM) begin
               if (cnt_q == '0) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b0;
                  rsp_data_d  = ext_data;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end else if (dev_rvalid) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_data_d  = ext_data;
            end
`ifdef MEM_RSP_TIMEOUT_EN
            else if (cnt_q == '0) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_data_d  = 32'h0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
`else
            else begin
               cnt_d = cnt_q;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sel_q        <= 2'b00;
         addr_q       <= 32'h0;
         f3_q         <= 3'b000;
         cnt_q        <= '0;
         sram_rd_en_q <= 1'b0;
         uart_rd_en_q <= 1'b0;
         i2c_rd_en_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_data_q   <= 32'h0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         addr_q       <= addr_d;
         f3_q         <= f3_d;
         cnt_q        <= cnt_d;
         sram_rd_en_q <= sram_rd_en_d;
         uart_rd_en_q <= uart_rd_en_d;
         i2c_rd_en_q  <= i2c_rd_en_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         rsp_data_q   <= rsp_data_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign rd_addr    = addr_q;
   assign sram_rd_en = sram_rd_en_q;
   assign uart_rd_en = uart_rd_en_q;
   assign i2c_rd_en  = i2c_rd_en_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_mem_read_resp.sv
// tb_mem_read_resp: directed and randomized checks of mem_read_resp against
// a load-semantics reference model. Honors MEM_RSP_TIMEOUT_EN.
module tb_mem_read_resp;

   localparam int SRAM_LAT = 1;
   localparam int TO_CYC   = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_mem_sel = 2'b00;
   logic [31:0] req_addr = 32'h0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] rd_addr;
   logic        sram_rd_en, uart_rd_en, i2c_rd_en;
   logic [31:0] sram_rdata;
   logic [31:0] uart_rdata = 32'h0;
   logic        uart_rvalid = 1'b0;
   logic [31:0] i2c_rdata = 32'h0;
   logic        i2c_rvalid = 1'b0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_read_resp #(.SRAM_LAT(SRAM_LAT), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_mem_sel(req_mem_sel), .req_addr(req_addr), .req_funct3(req_funct3),
      .rd_addr(rd_addr),
      .sram_rd_en(sram_rd_en), .uart_rd_en(uart_rd_en), .i2c_rd_en(i2c_rd_en),
      .sram_rdata(sram_rdata),
      .uart_rdata(uart_rdata), .uart_rvalid(uart_rvalid),
      .i2c_rdata(i2c_rdata), .i2c_rvalid(i2c_rvalid),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   // SRAM model: the word is only on the bus exactly SRAM_LAT cycles after the strobe.
   logic [31:0]       sram_word = 32'h0;
   logic [SRAM_LAT:0] sram_pipe;
   always @(posedge clk) begin
      if (rst) sram_pipe <= '0;
      else     sram_pipe <= {sram_pipe[SRAM_LAT-1:0], sram_rd_en};
   end
   assign sram_rdata = sram_pipe[SRAM_LAT-1] ? sram_word : ~sram_word;

   // Reference load semantics: {err, data}.
   function automatic logic [32:0] ref_load(input logic [1:0] sel, input logic [31:0] addr,
                                            input logic [2:0] f3, input logic [31:0] w);
      int unsigned b, h, ofs;
      ofs = addr % 4;
      b = (w >> (8 * ofs)) & 32'hFF;
      h = (w >> (16 * (ofs / 2))) & 32'hFFFF;
      if (sel == 2'd3) return {1'b1, 32'h0};
      case (f3)
         3'd0: return {1'b0, (b >= 128) ? (b | 32'hFFFF_FF00) : b};
         3'd4: return {1'b0, b};
         3'd1: return (ofs % 2 != 0) ? {1'b1, 32'h0} : {1'b0, (h >= 32768) ? (h | 32'hFFFF_0000) : h};
         3'd5: return (ofs % 2 != 0) ? {1'b1, 32'h0} : {1'b0, h};
         3'd2: return (ofs != 0) ? {1'b1, 32'h0} : {1'b0, w};
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   // Observations filled in by do_txn.
   int          obs_rsp_cyc, obs_strobe_cyc, obs_sram_n, obs_uart_n, obs_i2c_n;
   logic [31:0] obs_data, obs_rdaddr;
   logic        obs_err, obs_acc_ready, obs_after_valid, obs_after_ready;

   // Drive one request starting at a negedge, play the device side and record
   // what the DUT did. Response cycle counts from the accept edge (1 = next cycle).
   task automatic do_txn(input logic [1:0] sel, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] word, input int dly, input bit noise, input int budget);
      obs_rsp_cyc = 0; obs_strobe_cyc = 0; obs_sram_n = 0; obs_uart_n = 0; obs_i2c_n = 0;
      obs_data = 32'h0; obs_rdaddr = 32'h0; obs_err = 1'b0;
      sram_word = word;
      req_valid = 1'b1; req_mem_sel = sel; req_addr = addr; req_funct3 = f3;
      obs_acc_ready = req_ready;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         req_valid = 1'b0; req_addr = $urandom; req_funct3 = 3'($urandom); req_mem_sel = 2'($urandom);
         uart_rvalid = 1'b0; i2c_rvalid = 1'b0; uart_rdata = $urandom; i2c_rdata = $urandom;
         if (sram_rd_en) obs_sram_n++;
         if (uart_rd_en) obs_uart_n++;
         if (i2c_rd_en)  obs_i2c_n++;
         if (sram_rd_en || uart_rd_en || i2c_rd_en) begin
            obs_strobe_cyc = k; obs_rdaddr = rd_addr;
         end
         if (obs_strobe_cyc > 0 && k == obs_strobe_cyc + dly) begin
            if (sel == 2'd1) begin uart_rvalid = 1'b1; uart_rdata = word; end
            if (sel == 2'd2) begin i2c_rvalid = 1'b1;  i2c_rdata = word;  end
         end
         if (noise && obs_strobe_cyc > 0 && dly >= 2 && k == obs_strobe_cyc + 1) begin
            if (sel == 2'd2) begin uart_rvalid = 1'b1; uart_rdata = ~word; end
            else             begin i2c_rvalid = 1'b1;  i2c_rdata = ~word;  end
         end
         if (rsp_valid) begin
            obs_rsp_cyc = k; obs_data = rsp_data; obs_err = rsp_err;
            break;
         end
      end
      @(negedge clk);
      uart_rvalid = 1'b0; i2c_rvalid = 1'b0;
      obs_after_valid = rsp_valid;
      obs_after_ready = req_ready;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if ({sram_rd_en, uart_rd_en, i2c_rd_en, rsp_valid, rsp_err} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {sram_rd_en, uart_rd_en, i2c_rd_en, rsp_valid, rsp_err});
      end
      n_checks++;
      if (rsp_data !== 32'h0 || rd_addr !== 32'h0) begin
         n_fail++; $display("FAIL reset_data: rsp_data=%h rd_addr=%h want 0", rsp_data, rd_addr);
      end
      n_checks++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_sram_lw();
      do_txn(2'd0, 32'h0, 3'd2, 32'hDEAD_BEEF, 0, 1'b0, 20);
      n_checks++;
      if (obs_sram_n !== 1 || obs_uart_n !== 0 || obs_i2c_n !== 0 || obs_strobe_cyc !== 1) begin
         n_fail++; $display("FAIL sram_lw_strobe: sram=%0d uart=%0d i2c=%0d cyc=%0d want 1 0 0 1", obs_sram_n, obs_uart_n, obs_i2c_n, obs_strobe_cyc);
      end
      n_checks++;
      if (obs_rsp_cyc !== SRAM_LAT + 2) begin n_fail++; $display("FAIL sram_lw_lat: got %0d want %0d", obs_rsp_cyc, SRAM_LAT + 2); end
      n_checks++;
      if (obs_data !== 32'hDEAD_BEEF || obs_err !== 1'b0) begin
         n_fail++; $display("FAIL sram_lw_data: got %h err=%b want deadbeef err=0", obs_data, obs_err);
      end
      n_checks++;
      if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin
         n_fail++; $display("FAIL sram_lw_pulse: valid=%b ready=%b want 0 1", obs_after_valid, obs_after_ready);
      end
   endtask

   task automatic test_sram_byte();
      do_txn(2'd0, 32'h0000_0103, 3'd0, 32'h80FF_0000, 0, 1'b0, 20);
      n_checks++;
      if (obs_data !== 32'hFFFF_FF80 || obs_err !== 1'b0) begin
         n_fail++; $display("FAIL sram_lb: got %h err=%b want ffffff80 err=0", obs_data, obs_err);
      end
      n_checks++;
      if (obs_rdaddr !== 32'h0000_0103) begin n_fail++; $display("FAIL sram_lb_rdaddr: got %h want 00000103", obs_rdaddr); end
      do_txn(2'd0, 32'h0000_0103, 3'd4, 32'h80FF_0000, 0, 1'b0, 20);
      n_checks++;
      if (obs_data !== 32'h0000_0080 || obs_err !== 1'b0) begin
         n_fail++; $display("FAIL sram_lbu: got %h err=%b want 00000080 err=0", obs_data, obs_err);
      end
   endtask

   task automatic test_uart();
      do_txn(2'd1, 32'h0000_0010, 3'd2, 32'h0000_0041, 6, 1'b1, 40);
      n_checks++;
      if (obs_uart_n !== 1 || obs_sram_n !== 0 || obs_i2c_n !== 0) begin
         n_fail++; $display("FAIL uart_strobe: sram=%0d uart=%0d i2c=%0d want 0 1 0", obs_sram_n, obs_uart_n, obs_i2c_n);
      end
      n_checks++;
      if (obs_rsp_cyc !== 8) begin n_fail++; $display("FAIL uart_lat: got %0d want 8", obs_rsp_cyc); end
      n_checks++;
      if (obs_data !== 32'h41 || obs_err !== 1'b0) begin
         n_fail++; $display("FAIL uart_data: got %h err=%b want 00000041 err=0", obs_data, obs_err);
      end
   endtask

   task automatic test_errors();
      do_txn(2'd0, 32'h0000_0002, 3'd2, 32'h1234_5678, 0, 1'b0, 20);
      n_checks++;
      if (obs_sram_n + obs_uart_n + obs_i2c_n !== 0 || obs_rsp_cyc !== 1) begin
         n_fail++; $display("FAIL err_misalign_flow: strobes=%0d rsp_cyc=%0d want 0 1", obs_sram_n + obs_uart_n + obs_i2c_n, obs_rsp_cyc);
      end
      n_checks++;
      if (obs_err !== 1'b1 || obs_data !== 32'h0) begin
         n_fail++; $display("FAIL err_misalign_rsp: err=%b data=%h want 1 0", obs_err, obs_data);
      end
      do_txn(2'd3, 32'h0, 3'd2, 32'h1234_5678, 0, 1'b0, 20);
      n_checks++;
      if (obs_sram_n + obs_uart_n + obs_i2c_n !== 0 || obs_rsp_cyc !== 1 || obs_err !== 1'b1 || obs_data !== 32'h0) begin
         n_fail++; $display("FAIL err_unmapped: strobes=%0d cyc=%0d err=%b data=%h want 0 1 1 0", obs_sram_n + obs_uart_n + obs_i2c_n, obs_rsp_cyc, obs_err, obs_data);
      end
   endtask

   task automatic test_timeout();
`ifdef MEM_RSP_TIMEOUT_EN
      do_txn(2'd2, 32'h0, 3'd2, 32'hCAFE_F00D, 100000, 1'b0, 50);
      n_checks++;
      if (obs_rsp_cyc !== TO_CYC + 2 || obs_err !== 1'b1 || obs_data !== 32'h0) begin
         n_fail++; $display("FAIL timeout: cyc=%0d err=%b data=%h want %0d 1 0", obs_rsp_cyc, obs_err, obs_data, TO_CYC + 2);
      end
`else
      do_txn(2'd2, 32'h0, 3'd2, 32'hCAFE_F00D, 100000, 1'b0, 100);
      n_checks++;
      if (obs_rsp_cyc !== 0 || obs_after_ready !== 1'b0) begin
         n_fail++; $display("FAIL no_timeout_hold: rsp_cyc=%0d ready=%b want 0 0", obs_rsp_cyc, obs_after_ready);
      end
      apply_reset();
`endif
   endtask

   task automatic test_mid_reset();
      sram_word = 32'h5555_AAAA;
      req_valid = 1'b1; req_mem_sel = 2'd0; req_addr = 32'h0; req_funct3 = 3'd2;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || sram_rd_en !== 1'b0) begin
         n_fail++; $display("FAIL midrst_drop: valid=%b sram_rd_en=%b want 0 0", rsp_valid, sram_rd_en);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL midrst_ready: ready=%b valid=%b want 1 0", req_ready, rsp_valid);
      end
      uart_rvalid = 1'b1; uart_rdata = 32'h77;
      @(negedge clk);
      uart_rvalid = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++; $display("FAIL late_rvalid: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] v_seen, r_seen;
      v_seen = '0; r_seen = '0;
      req_valid = 1'b1; req_mem_sel = 2'd3; req_addr = 32'h0; req_funct3 = 3'd2;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         v_seen[k-1] = rsp_valid;
         r_seen[k-1] = req_ready;
      end
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (v_seen !== 4'b0101 || r_seen !== 4'b1010) begin
         n_fail++; $display("FAIL back_to_back: valid=%b ready=%b want 0101 1010", v_seen, r_seen);
      end
   endtask

   task automatic test_random();
      logic [2:0]  legal [5];
      logic [1:0]  sel;
      logic [31:0] addr, word;
      logic [2:0]  f3;
      logic [32:0] exp;
      int          dly, exp_cyc, exp_s, exp_u, exp_i;
      legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      for (int t = 0; t < 40; t++) begin
         sel  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         addr = $urandom;
         word = $urandom;
         f3   = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
         dly  = $urandom_range(0, 7);
         exp  = ref_load(sel, addr, f3, word);
         exp_s = (!exp[32] && sel == 2'd0) ? 1 : 0;
         exp_u = (!exp[32] && sel == 2'd1) ? 1 : 0;
         exp_i = (!exp[32] && sel == 2'd2) ? 1 : 0;
         exp_cyc = exp[32] ? 1 : (sel == 2'd0) ? SRAM_LAT + 2 : dly + 2;
         do_txn(sel, addr, f3, word, dly, 1'($urandom), 30);
         n_checks++;
         if (obs_rsp_cyc !== exp_cyc || obs_acc_ready !== 1'b1) begin
            n_fail++; $display("FAIL rnd%0d_lat: got %0d want %0d (ready %b)", t, obs_rsp_cyc, exp_cyc, obs_acc_ready);
         end
         n_checks++;
         if (obs_err !== exp[32] || obs_data !== exp[31:0]) begin
            n_fail++; $display("FAIL rnd%0d_rsp: sel=%0d f3=%0d addr=%h word=%h got err=%b data=%h want err=%b data=%h",
                               t, sel, f3, addr, word, obs_err, obs_data, exp[32], exp[31:0]);
         end
         n_checks++;
         if (obs_sram_n !== exp_s || obs_uart_n !== exp_u || obs_i2c_n !== exp_i) begin
            n_fail++; $display("FAIL rnd%0d_strobe: got %0d %0d %0d want %0d %0d %0d", t, obs_sram_n, obs_uart_n, obs_i2c_n, exp_s, exp_u, exp_i);
         end
         n_checks++;
         if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin
            n_fail++; $display("FAIL rnd%0d_pulse: valid=%b ready=%b want 0 1", t, obs_after_valid, obs_after_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sram_lw();
      test_sram_byte();
      test_uart();
      test_errors();
      test_timeout();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
      $fatal(1);
   end

endmodule
